// File: rtl/stream_serializer_if.sv
// stream_serializer_if: valid/ready stream bundle used on both sides of the serializer.
// The slave side carries no TLAST because input words are not framed.
interface stream_serializer_if #(parameter int W = 8);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer: splits DATA_WIDTH input words into DATA_WIDTH/OUT_WIDTH output chunks.
// Define STREAM_SERIALIZER_LSB_FIRST_EN for LSB-first chunk order (default MSB-first).
module stream_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic clk,
    input  logic aresetn,
    stream_serializer_if.slave  s_axis,
    stream_serializer_if.master m_axis
);
    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t                state_q, state_nx;
    logic [DATA_WIDTH-1:0] word_q, word_nx, word_adv;
    logic [CW-1:0]         cnt_q, cnt_nx;
    logic                  last, in_xfer, out_xfer;

    assign last           = cnt_q == LAST_IDX;
    assign s_axis.tready  = state_q == EMPTY || (last && m_axis.tready);
    assign m_axis.tvalid  = state_q == BUSY;
    assign m_axis.tlast   = state_q == BUSY && last;
    assign in_xfer        = s_axis.tvalid && s_axis.tready;
    assign out_xfer       = m_axis.tvalid && m_axis.tready;

    // The presented chunk always sits at a fixed end of the word register
`ifdef STREAM_SERIALIZER_LSB_FIRST_EN
    assign word_adv       = word_q >> OUT_WIDTH;
    assign m_axis.tdata   = word_q[OUT_WIDTH-1:0];
`else
    assign word_adv       = word_q << OUT_WIDTH;
    assign m_axis.tdata   = word_q[DATA_WIDTH-1 -: OUT_WIDTH];
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            word_q  <= word_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // An input transfer while BUSY implies the final chunk leaves in the same cycle
    always_comb begin
        state_nx = state_q;
        word_nx  = word_q;
        cnt_nx   = cnt_q;
        if (in_xfer) begin
            state_nx = BUSY;
            word_nx  = s_axis.tdata;
            cnt_nx   = '0;
        end else if (out_xfer) begin
            state_nx = last ? EMPTY : BUSY;
            word_nx  = last ? word_q : word_adv;
            cnt_nx   = last ? cnt_q : cnt_q + CW'(1);
        end
    end

    hold_stable: assert property (@(posedge clk) disable iff (!aresetn)
        m_axis.tvalid && !m_axis.tready |=> m_axis.tvalid && $stable(m_axis.tdata) && $stable(m_axis.tlast));

    busy_not_ready: assert property (@(posedge clk) disable iff (!aresetn)
        m_axis.tvalid && !m_axis.tlast |-> !s_axis.tready);
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: table vectors, directed corner sequences and random scoreboard run.
module tb_stream_serializer;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    stream_serializer_if #(.W(32)) s_if();
    stream_serializer_if #(.W(8))  m_if();

    stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk(clk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Chunk n of a word, in the configured output order
    function automatic logic [7:0] chunk_of(input logic [31:0] w, input int n);
`ifdef STREAM_SERIALIZER_LSB_FIRST_EN
        return w[n*8 +: 8];
`else
        return w[31-n*8 -: 8];
`endif
    endfunction

    function automatic int order_idx(input int n);
`ifdef STREAM_SERIALIZER_LSB_FIRST_EN
        return 3 - n;
`else
        return n;
`endif
    endfunction

    typedef struct {
        logic [31:0] word;
        logic [7:0]  msb_chunks [4];
    } vec_t;

    vec_t tbl [5];

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = w;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        #1;
    endtask

    task automatic drain_check(input logic [31:0] w, input string tag);
        for (int n = 0; n < 4; n++) begin
            chk({tag, "_valid"}, m_if.tvalid, 1);
            chk({tag, "_data"}, m_if.tdata, chunk_of(w, n));
            chk({tag, "_last"}, m_if.tlast, n == 3);
            @(negedge clk);
            #1;
        end
        chk({tag, "_idle"}, m_if.tvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] wa, wb, w;
        logic [7:0]  q_d [$];
        logic        q_l [$];
        logic [7:0]  ed;
        logic        el, acc;
        int words, got, lasts, cyc;

        tbl[0] = '{32'h11223344, '{8'h11, 8'h22, 8'h33, 8'h44}};
        tbl[1] = '{32'hDEADBEEF, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        tbl[2] = '{32'h00000000, '{8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[3] = '{32'hFFFFFFFF, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[4] = '{32'h80000001, '{8'h80, 8'h00, 8'h00, 8'h01}};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        #2;
        chk("rst_valid", m_if.tvalid, 0);
        chk("rst_last", m_if.tlast, 0);
        chk("rst_data", m_if.tdata, 0);
        chk("rst_sready", s_if.tready, 1);
        @(negedge clk);
        aresetn = 1'b1;

        // Table vectors with downstream always ready
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = tbl[v].word;
            #1;
            chk("tbl_idle_sready", s_if.tready, 1);
            chk("tbl_idle_valid", m_if.tvalid, 0);
            @(negedge clk);
            s_if.tvalid = 1'b0;
            #1;
            for (int n = 0; n < 4; n++) begin
                chk("tbl_valid", m_if.tvalid, 1);
                chk("tbl_data", m_if.tdata, tbl[v].msb_chunks[order_idx(n)]);
                chk("tbl_last", m_if.tlast, n == 3);
                chk("tbl_sready", s_if.tready, n == 3);
                @(negedge clk);
                #1;
            end
            chk("tbl_done", m_if.tvalid, 0);
        end

        // Back-to-back words, no bubble between them
        wa = 32'hAABBCCDD;
        wb = 32'h01020304;
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = wa;
        @(negedge clk);
        s_if.tdata  = wb;
        #1;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? wa : wb;
            chk("b2b_valid", m_if.tvalid, 1);
            chk("b2b_data", m_if.tdata, chunk_of(w, i % 4));
            chk("b2b_last", m_if.tlast, (i % 4) == 3);
            chk("b2b_sready", s_if.tready, (i % 4) == 3);
            if (i == 7) s_if.tvalid = 1'b0;
            @(negedge clk);
            #1;
        end
        chk("b2b_done", m_if.tvalid, 0);

        // Downstream stall on the second chunk
        w = 32'h11223344;
        send_word(w);
        chk("stall_c0", m_if.tdata, chunk_of(w, 0));
        @(negedge clk);
        m_if.tready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", m_if.tdata, chunk_of(w, 1));
            chk("stall_valid", m_if.tvalid, 1);
            chk("stall_last", m_if.tlast, 0);
            chk("stall_sready", s_if.tready, 0);
            @(negedge clk);
            #1;
        end
        m_if.tready = 1'b1;
        #1;
        chk("stall_resume_c1", m_if.tdata, chunk_of(w, 1));
        @(negedge clk);
        #1;
        chk("stall_resume_c2", m_if.tdata, chunk_of(w, 2));
        @(negedge clk);
        #1;
        chk("stall_resume_c3", m_if.tdata, chunk_of(w, 3));
        chk("stall_resume_last", m_if.tlast, 1);
        @(negedge clk);
        #1;
        chk("stall_done", m_if.tvalid, 0);

        // Reset mid-word discards the remaining chunks
        send_word(w);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_c2", m_if.tdata, chunk_of(w, 2));
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", m_if.tvalid, 0);
        chk("mid_rst_last", m_if.tlast, 0);
        chk("mid_rst_data", m_if.tdata, 0);
        chk("mid_rst_sready", s_if.tready, 1);
        @(negedge clk);
        #1;
        chk("mid_rst_hold_valid", m_if.tvalid, 0);
        aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", m_if.tvalid, 0);
        end
        send_word(32'h55667788);
        drain_check(32'h55667788, "post_rst");

        // Random handshake stress against a chunk queue model
        words = 0;
        got   = 0;
        lasts = 0;
        cyc   = 0;
        acc   = 1'b0;
        while ((words < 1000 || q_d.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) s_if.tvalid = 1'b0;
            acc = 1'b0;
            if (!s_if.tvalid && words < 1000 && $urandom_range(3) != 0) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = $urandom;
            end
            m_if.tready = $urandom_range(3) != 0;
            #1;
            if (m_if.tvalid && m_if.tready) begin
                if (q_d.size() == 0) begin
                    chk("rnd_spurious_valid", m_if.tvalid, 0);
                end else begin
                    ed = q_d.pop_front();
                    el = q_l.pop_front();
                    chk("rnd_data", m_if.tdata, ed);
                    chk("rnd_last", m_if.tlast, el);
                    got++;
                    if (m_if.tlast) lasts++;
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                for (int n = 0; n < 4; n++) begin
                    q_d.push_back(chunk_of(s_if.tdata, n));
                    q_l.push_back(n == 3);
                end
                words++;
                acc = 1'b1;
            end
        end
        s_if.tvalid = 1'b0;
        chk("rnd_in_budget", cyc < 20000, 1);
        chk("rnd_chunks", got, 4000);
        chk("rnd_lasts", lasts, 1000);
        chk("rnd_queue_empty", q_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
